// File: rtl/pe_mac_sequencer.sv
// Sequences one PE16 multiply-accumulate element through a K-term FP16 dot
// product with bias, closing the accumulation loop through the PE's sum_out.
module pe_mac_sequencer #(
  parameter int unsigned LEN_W      = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  output logic [DATA_WIDTH-1:0] pe_sum_in,
  input  logic [DATA_WIDTH-1:0] pe_sum_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0]   res_data_d;

  // State, counter, result and handshake flags; flags track the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      res_data    <= '0;
      cmd_ready   <= 1'b1;
      in_ready    <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      res_data    <= res_data_d;
      cmd_ready   <= (state_d == S_IDLE);
      in_ready    <= (state_d == S_RUN);
      res_valid   <= (state_d == S_DONE);
      busy        <= (state_d != S_IDLE);
    end
  end

  // Next state and PE drive; zero operands make the PE hold sum_in.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    res_data_d  = res_data;
    pe_a        = '0;
    pe_b        = '0;
    pe_sum_in   = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && !rst) begin
          pe_sum_in   = cmd_bias;
          remaining_d = cmd_len;
          state_d     = (cmd_len != '0) ? S_RUN : S_CAPT;
        end
      end
      S_RUN: begin
        pe_sum_in = pe_sum_out;
        if (in_valid) begin
          pe_a = in_a;
          pe_b = in_b;
          if (remaining_q != '0) remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q <= LEN_W'(1)) state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        pe_sum_in  = pe_sum_out;
        res_data_d = pe_sum_out;
        state_d    = S_DONE;
      end
      S_DONE: begin
        pe_sum_in = pe_sum_out;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/pe_mac_sequencer.md
# pe_mac_sequencer

Controller that sequences one PE16 floating-point multiply-accumulate processing element through a K-term FP16 dot product with bias. It accepts a command with a length and bias, then streams operand pairs from an upstream valid/ready source into the PE. It closes the accumulation loop through the PE's registered `sum_out`, inserting hold cycles on input stalls, and returns the final sum on a valid/ready result port. It sits between the convolution operand fetch logic and a PE16 instance in the convolution unit.

## Interface
- `LEN_W`, 10: width of the command length field; max terms = 2^LEN_W - 1.
- `DATA_WIDTH`, 16: FP16 word width. Fixed at 16.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset. Asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high exactly in IDLE.
- `cmd_len`  in  LEN_W  number of operand pairs K, 0 allowed.
- `cmd_bias`  in  16  FP16 initial accumulator value.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  high exactly in RUN.
- `in_a`, `in_b`  in  16 each  FP16 operands.
- `res_valid`  out  1  result present; high exactly in DONE.
- `res_ready`  in  1  result consumer ready.
- `res_data`  out  16  registered FP16 result.
- `busy`  out  1  state != IDLE.
- `pe_a`, `pe_b`, `pe_sum_in`  out  16 each  drive PE16 `floatA`, `floatB` and `sum_in`.
- `pe_sum_out`  in  16  PE16 registered `sum_out`.

## Operation
States: IDLE, RUN, CAPT, DONE. Reset state is IDLE.

IDLE:
- `cmd_ready` = 1.
- With no command: `pe_a` = `pe_b` = `pe_sum_in` = 0, which clears the PE accumulator.
- On `cmd_valid`: drive `pe_a` = `pe_b` = 0 and `pe_sum_in` = `cmd_bias`, so the PE register holds the bias next cycle. Load `remaining` = `cmd_len`.
- Next state is RUN if `cmd_len` != 0, else CAPT.

RUN:
- `in_ready` = 1 and `pe_sum_in` = `pe_sum_out`.
- Beat (`in_valid` = 1): `pe_a` = `in_a`, `pe_b` = `in_b`, and `remaining` decrements. When the last beat is taken (`remaining` = 1), go to CAPT.
- Stall (`in_valid` = 0): `pe_a` = `pe_b` = 0. The product is 0, so the adder returns `sum_in` unchanged and the accumulator holds.

CAPT:
- `pe_a` = `pe_b` = 0 and `pe_sum_in` = `pe_sum_out`.
- Latch `res_data` <= `pe_sum_out`, then go to DONE.

DONE:
- `res_valid` = 1. `res_data` and the PE hold inputs stay stable.
- On `res_ready`, go to IDLE. A command can first be accepted in the cycle after that.

General rules:
- `pe_*` outputs are combinational from state and inputs. `res_data` and the state are registered.
- Arithmetic (rounding, flush to zero on underflow) is entirely the PE's. The sequencer does no FP math.
- `remaining` is an unsigned LEN_W-bit down-counter and never wraps. It is only decremented in RUN while it is at least 1.
- `in_valid` while not in RUN is ignored; no beat is consumed. `cmd_valid` while not in IDLE is ignored.

## Timing
Reset (asserted, or asynchronously mid-operation):
- State goes to IDLE and `remaining` = 0.
- `res_data` = 0, `res_valid` = 0, `in_ready` = 0, `busy` = 0, `cmd_ready` = 1.
- `pe_a`, `pe_b` and `pe_sum_in` = 0.
- Any partial accumulation is discarded. The PE's own reset is handled separately by the integrator; after the first IDLE cycle the PE holds 0 regardless.

Latency and throughput:
- Command accepted in cycle C. RUN starts at C+1.
- The last beat is accepted in cycle T. CAPT is at T+1 and `res_valid` rises at T+2.
- With no stalls, T = C+K, so `res_valid` is at C+K+2.
- K = 0: CAPT at C+1, `res_valid` at C+2, `res_data` = `cmd_bias`.
- Throughput is one operand pair per cycle in RUN.
- Minimum command-to-command spacing is K+3 cycles, with the result accepted in its first valid cycle.

Handshakes:
- A transfer happens when valid && ready on a rising edge.
- `res_valid` and `res_data` hold until `res_ready`.

## Test plan
- Basic dot product: bias 0x0000, K=3, pairs (0x3C00, 0x4000), (0x4000, 0x4000), (0x3800, 0x4400) with no stalls -> `res_data` = 0x4800 (8.0), `res_valid` at C+5.
- Zero length: bias 0x4200, K=0 -> `in_ready` never rises, `res_valid` at C+2, `res_data` = 0x4200.
- Input stalls: bias 0x3C00, K=2, pair (0x4000, 0x4200), then 3 idle cycles, then pair (0x3C00, 0x4400) -> `pe_sum_out` = 0x4700 constant through the stalls, `res_data` = 0x4980 (11.0).
- Result backpressure: `res_ready` held low for 5 cycles -> `res_valid` = 1, `res_data` and `pe_sum_out` stable, `cmd_ready` = 0, a pending `cmd_valid` is not accepted until the cycle after `res_ready`.
- Reset mid-RUN after 2 of 4 beats -> all outputs at their reset values immediately. A new command with bias 0, K=1, pair (0x4000, 0x4000) then gives 0x4400 with no residue from the aborted job.
- Back-to-back commands: `cmd_valid` held with two queued jobs -> the second command is accepted exactly one cycle after the first result's handshake, and both results are correct.
